// File: rtl/pcpu_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pcpu_mem_pkg                                          |
// | Brief    : Shared types and constants for the pcpu memory system |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package pcpu_mem_pkg;

  // Loader / CPU-handoff state encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    DRAIN = 3'd3,
    KICK  = 3'd4,
    RUN   = 3'd5
  } state_e;

  // Instruction word presented to the CPU while it is not running
  localparam logic [15:0] NOP_WORD = 16'h0000;

  // Loader target memory select
  localparam logic SEL_IMEM = 1'b0;
  localparam logic SEL_DMEM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pcpu_mem_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pcpu_mem_loader                                       |
// | Brief    : Byte-stream image loader FSM, word assembler, write   |
// |            pointer, error flag and CPU start/enable handoff      |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
import pcpu_mem_pkg::*;

module pcpu_mem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  input  logic              ld_sel,
  output logic              ld_ready,
  output logic              busy,
  output logic              ld_err,
  output logic              cpu_start,
  output logic              cpu_enable,
  output state_e            state,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data
);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [7:0]        hi_q, hi_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic              enable_q, enable_d;
  logic              xfer;

  // Bytes are only accepted in the image states and never while reset is held
  assign ld_ready = !reset && (state_q inside {IDLE, HI, LO, DRAIN});
  assign xfer     = ld_valid && ld_ready;
  assign busy     = state_q inside {HI, LO, DRAIN};

  assign ld_err     = err_q;
  assign cpu_start  = start_q;
  assign cpu_enable = enable_q;
  assign state      = state_q;

  // A word is written when its low byte is accepted; the pointer stays below
  // the overflow bit whenever a write can happen
  assign wr_en   = xfer && (state_q == LO);
  assign wr_sel  = sel_q;
  assign wr_addr = ptr_q[ADDR_W-1:0];
  assign wr_data = {hi_q, ld_byte};

  // Next-state, byte assembly, pointer and error tracking
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    hi_d     = hi_q;
    err_d    = err_q;
    start_d  = 1'b0;
    enable_d = enable_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          sel_d = ld_sel;
          ptr_d = '0;
          hi_d  = ld_byte;
          if (ld_last) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            state_d = LO;
          end
        end
      end
      HI: begin
        if (xfer) begin
          if (ptr_q[ADDR_W]) begin
            // Memory already full: swallow the rest of the image
            err_d   = 1'b1;
            state_d = ld_last ? IDLE : DRAIN;
          end else if (ld_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            hi_d    = ld_byte;
            state_d = LO;
          end
        end
      end
      LO: begin
        if (xfer) begin
          ptr_d = ptr_q + 1'b1;
          if (!ld_last) begin
            state_d = HI;
          end else if (sel_q == SEL_DMEM) begin
            state_d = IDLE;
          end else begin
            state_d  = KICK;
            start_d  = 1'b1;
            enable_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (xfer && ld_last) begin
          state_d = IDLE;
        end
      end
      KICK: begin
        state_d  = RUN;
        enable_d = 1'b1;
      end
      RUN: begin
        enable_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= SEL_IMEM;
      ptr_q    <= '0;
      hi_q     <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      hi_q     <= hi_d;
      err_q    <= err_d;
      start_q  <= start_d;
      enable_q <= enable_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pcpu_mem_sys.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pcpu_mem_sys                                          |
// | Brief    : Instruction/data memories for the 16-bit pipelined    |
// |            CPU with a byte-stream image loader                   |
// | Options  : PCPU_MEM_DUMP_EN adds a dmem readback port            |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
import pcpu_mem_pkg::*;

module pcpu_mem_sys #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [15:0]       instruction,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              wena,
  input  logic [15:0]       dataout,
  output logic [15:0]       datain,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  input  logic              ld_sel,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic              busy,
  output logic              ld_err
`ifdef PCPU_MEM_DUMP_EN
  ,
  input  logic [ADDR_W-1:0] dump_addr,
  output logic [15:0]       dump_data
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [15:0]       imem_q [0:DEPTH-1];
  logic [15:0]       dmem_q [0:DEPTH-1];
  state_e            state;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  pcpu_mem_loader #(
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .ld_sel     (ld_sel),
    .ld_ready   (ld_ready),
    .busy       (busy),
    .ld_err     (ld_err),
    .cpu_start  (cpu_start),
    .cpu_enable (cpu_enable),
    .state      (state),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  // Instruction memory is written only by the loader
  always_ff @(posedge clk) begin
    if (wr_en && (wr_sel == SEL_IMEM)) begin
      imem_q[wr_addr] <= wr_data;
    end
  end

  // Data memory: loader writes, or CPU stores once the program is running
  always_ff @(posedge clk) begin
    if (wr_en && (wr_sel == SEL_DMEM)) begin
      dmem_q[wr_addr] <= wr_data;
    end else if (wena && (state == RUN)) begin
      dmem_q[d_addr] <= dataout;
    end
  end

  // The CPU sees NOPs until the image has been handed over
  assign instruction = ((state == KICK) || (state == RUN)) ? imem_q[i_addr] : NOP_WORD;
  assign datain      = dmem_q[d_addr];

`ifdef PCPU_MEM_DUMP_EN
  assign dump_data = dmem_q[dump_addr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcpu_mem_sys.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_pcpu_mem_sys                                       |
// | Brief    : Self-checking bench for pcpu_mem_sys                  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_pcpu_mem_sys;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  i_addr = '0;
  logic [15:0] instruction;
  logic [7:0]  d_addr = '0;
  logic        wena = 1'b0;
  logic [15:0] dataout = '0;
  logic [15:0] datain;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [7:0]  ld_byte = '0;
  logic        ld_last = 1'b0;
  logic        ld_sel = 1'b0;
  logic        cpu_enable;
  logic        cpu_start;
  logic        busy;
  logic        ld_err;
`ifdef PCPU_MEM_DUMP_EN
  logic [7:0]  dump_addr = '0;
  logic [15:0] dump_data;
`endif

  pcpu_mem_sys #(.ADDR_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_addr      (i_addr),
    .instruction (instruction),
    .d_addr      (d_addr),
    .wena        (wena),
    .dataout     (dataout),
    .datain      (datain),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_byte     (ld_byte),
    .ld_last     (ld_last),
    .ld_sel      (ld_sel),
    .cpu_enable  (cpu_enable),
    .cpu_start   (cpu_start),
    .busy        (busy),
    .ld_err      (ld_err)
`ifdef PCPU_MEM_DUMP_EN
    ,
    .dump_addr   (dump_addr),
    .dump_data   (dump_data)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int start_cnt = 0;

  // Reference memory contents plus which words are known
  logic [15:0] m_imem [256];
  logic [15:0] m_dmem [256];
  bit          m_iv   [256];
  bit          m_dv   [256];

  always @(negedge clk) if (cpu_start === 1'b1) start_cnt++;

  typedef struct {
    logic        sel;
    int          n;
    logic [31:0] bytes;
    logic        err;
    logic        kick;
    logic [15:0] w0;
    logic [15:0] w1;
    int          bub;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Image outcome from the loader rules: words are byte pairs, at most 256
  // fit, odd length or overflow is an error, clean imem images start the CPU
  task automatic model_image(input logic [7:0] q[$], input logic sel,
                             output logic e_err, output logic e_kick);
    int n = q.size();
    int nw = n / 2;
    if (nw > 256) nw = 256;
    for (int w = 0; w < nw; w++) begin
      if (sel) begin m_dmem[w] = {q[2*w], q[2*w+1]}; m_dv[w] = 1'b1; end
      else     begin m_imem[w] = {q[2*w], q[2*w+1]}; m_iv[w] = 1'b1; end
    end
    e_err  = (n % 2 == 1) || (n > 512);
    e_kick = !e_err && (sel == 1'b0);
  endtask

  task automatic send_image(input logic [7:0] q[$], input logic sel, input int bub);
    int guard;
    @(negedge clk);
    for (int i = 0; i < q.size(); i++) begin
      while ($urandom_range(99) < bub) begin
        ld_valid = 1'b0;
        ld_sel   = 1'($urandom);
        @(negedge clk);
      end
      ld_valid = 1'b1;
      ld_byte  = q[i];
      ld_last  = (i == q.size() - 1);
      ld_sel   = (i == 0) ? sel : 1'($urandom);
      guard = 0;
      while (ld_ready !== 1'b1 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        chk("ready_timeout", 0, 1);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic run_img(input logic [7:0] q[$], input logic sel, input int bub,
                         output logic e_err, output logic e_kick);
    int s0 = start_cnt;
    int nw;
    model_image(q, sel, e_err, e_kick);
    send_image(q, sel, bub);
    chk("ld_err", ld_err, e_err);
    chk("busy_after", busy, 0);
    if (e_kick) begin
      chk("start_pulse", cpu_start, 1);
      chk("enable_kick", cpu_enable, 1);
      @(negedge clk); #1;
      chk("start_drop", cpu_start, 0);
      chk("enable_run", cpu_enable, 1);
      chk("ld_ready_run", ld_ready, 0);
      chk("start_count", start_cnt - s0, 1);
    end else begin
      chk("ready_idle", ld_ready, 1);
      chk("enable_off", cpu_enable, 0);
      #1;
      chk("start_count", start_cnt - s0, 0);
    end
    nw = q.size() / 2;
    if (nw > 256) nw = 256;
    for (int w = 0; w < nw; w++) begin
      @(negedge clk);
      if (sel) begin
        d_addr = 8'(w); #1;
        chk("dmem_word", datain, m_dmem[w]);
      end else if (e_kick) begin
        i_addr = 8'(w); #1;
        chk("imem_word", instruction, m_imem[w]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    ld_valid = 1'b0;
    wena     = 1'b0;
    @(negedge clk);
    chk("ready_in_reset", ld_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", ld_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", ld_err, 0);
    chk("rst_enable", cpu_enable, 0);
    chk("rst_start", cpu_start, 0);
    chk("rst_instr", instruction, 16'h0000);
  endtask

  initial begin
    logic [7:0] q[$];
    logic       e_err, e_kick;

    vecs[0] = '{1'b1, 4, 32'h12345678, 1'b0, 1'b0, 16'h1234, 16'h5678, 0};
    vecs[1] = '{1'b1, 3, 32'h11223300, 1'b1, 1'b0, 16'h1122, 16'h5678, 0};
    vecs[2] = '{1'b1, 1, 32'hAA000000, 1'b1, 1'b0, 16'h1122, 16'h5678, 0};
    vecs[3] = '{1'b1, 2, 32'hABCD0000, 1'b0, 1'b0, 16'hABCD, 16'h5678, 30};
    vecs[4] = '{1'b0, 4, 32'h20011000, 1'b0, 1'b1, 16'h2001, 16'h1000, 50};

    for (int i = 0; i < 256; i++) begin m_iv[i] = 1'b0; m_dv[i] = 1'b0; end

    i_addr = 8'd1;
    do_reset();

    // Directed image table
    for (int v = 0; v < 5; v++) begin
      logic [31:0] bw;
      bw = vecs[v].bytes;
      q = {};
      for (int b = 0; b < vecs[v].n; b++) q.push_back(bw[31-8*b -: 8]);
      run_img(q, vecs[v].sel, vecs[v].bub, e_err, e_kick);
      chk("tbl_err", ld_err, vecs[v].err);
      chk("tbl_enable", cpu_enable, vecs[v].kick);
      @(negedge clk);
      if (vecs[v].sel) begin
        d_addr = 8'd0; #1; chk("tbl_w0", datain, vecs[v].w0);
        @(negedge clk);
        d_addr = 8'd1; #1; chk("tbl_w1", datain, vecs[v].w1);
      end else begin
        i_addr = 8'd0; #1; chk("tbl_i0", instruction, vecs[v].w0);
        @(negedge clk);
        i_addr = 8'd1; #1; chk("tbl_i1", instruction, vecs[v].w1);
      end
    end

    // Odd imem image: error, no start, imem[1] untouched
    do_reset();
    q = {8'h11, 8'h22, 8'h33};
    run_img(q, 1'b0, 0, e_err, e_kick);
    q = {8'h30, 8'h03};
    run_img(q, 1'b0, 0, e_err, e_kick);
    @(negedge clk);
    i_addr = 8'd1; #1;
    chk("imem1_kept", instruction, 16'h1000);

    // Overflowing dmem image
    do_reset();
    q = {};
    for (int b = 0; b < 514; b++) q.push_back(8'($urandom));
    run_img(q, 1'b1, 10, e_err, e_kick);
    chk("ovf_err", ld_err, 1);

    // Reset in the middle of an image
    @(negedge clk);
    ld_valid = 1'b1; ld_byte = 8'h77; ld_sel = 1'b1; ld_last = 1'b0;
    #1;
    chk("mid_ready", ld_ready, 1);
    @(negedge clk);
    ld_valid = 1'b0;
    chk("mid_busy", busy, 1);
    do_reset();
    q = {8'h5A, 8'hA5};
    run_img(q, 1'b1, 0, e_err, e_kick);

    // Enter RUN and exercise CPU stores
    q = {8'h40, 8'h04};
    run_img(q, 1'b0, 0, e_err, e_kick);
    @(negedge clk);
    d_addr = 8'h10; wena = 1'b1; dataout = 16'hBEEF;
    #1;
    chk("rdw_old", datain, m_dmem[16]);
    @(negedge clk);
    wena = 1'b0;
    #1;
    chk("store_new", datain, 16'hBEEF);
    m_dmem[16] = 16'hBEEF;

    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      d_addr  = 8'($urandom);
      i_addr  = 8'($urandom);
      wena    = 1'($urandom);
      dataout = 16'($urandom);
      #1;
      if (m_dv[d_addr]) chk("run_datain", datain, m_dmem[d_addr]);
      if (m_iv[i_addr]) chk("run_instr", instruction, m_imem[i_addr]);
      if (wena) begin m_dmem[d_addr] = dataout; m_dv[d_addr] = 1'b1; end
    end
    @(negedge clk);
    wena = 1'b0;

    // Stores outside RUN are ignored
    do_reset();
    @(negedge clk);
    d_addr = 8'h10; wena = 1'b1; dataout = ~m_dmem[16];
    @(negedge clk);
    wena = 1'b0;
    #1;
    chk("idle_store_ignored", datain, m_dmem[16]);

    // Random dmem images
    for (int r = 0; r < 15; r++) begin
      int len;
      len = $urandom_range(1, 20);
      q = {};
      for (int b = 0; b < len; b++) q.push_back(8'($urandom));
      run_img(q, 1'b1, 30, e_err, e_kick);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/pcpu_mem_sys.md
# pcpu_mem_sys

Memory-side responder for the 16-bit pipelined CPU's instruction and data ports. It holds a 256×16 instruction memory and a 256×16 data memory, and answers the CPU's fetch, load and store traffic. A byte-stream loader fills either memory before execution. After an instruction image is loaded, the block asserts the CPU's start and enable inputs.

## Interface
Parameters:
- ADDR_W, 8, address width of both memories; depth is 2^ADDR_W words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_addr  in  ADDR_W  CPU fetch address.
- instruction  out  16  combinational read of imem[i_addr]; forced to 16'h0000 (NOP) unless state is KICK or RUN.
- d_addr  in  ADDR_W  CPU data address.
- wena  in  1  CPU store strobe.
- dataout  in  16  CPU store data.
- datain  out  16  combinational read of dmem[d_addr].
- ld_valid  in  1  loader byte valid.
- ld_ready  out  1  loader byte accept.
- ld_byte  in  8  loader byte.
- ld_last  in  1  marks the final byte of an image.
- ld_sel  in  1  target memory: 0 = imem, 1 = dmem. Sampled on the first byte of an image.
- cpu_enable  out  1  drives the CPU enable input.
- cpu_start  out  1  drives the CPU start input.
- busy  out  1  an image is in progress (state HI, LO or DRAIN).
- ld_err  out  1  sticky error flag for the last image.

## Operation
States:
- IDLE (reset state): ld_ready=1, waiting for the first byte.
  - First accept → sel_q<=ld_sel, ptr<=0, ld_err<=0, hi<=byte, go to LO.
  - If that first byte also carries ld_last → set ld_err, stay in IDLE.
- HI: accept high byte into hi, go to LO.
  - ld_last on a high byte → ld_err<=1, partial word discarded, go to IDLE.
- LO: accept low byte; write {hi, byte} into mem[sel_q][ptr]; ptr<=ptr+1.
  - Without ld_last → go to HI.
  - With ld_last and sel_q=1 → go to IDLE.
  - With ld_last and sel_q=0 → go to KICK.
- DRAIN: entered when a byte arrives while ptr==2^ADDR_W (overflow).
  - Sets ld_err; accepts and drops every byte until ld_last, then goes to IDLE. No start is issued.
- KICK: cpu_start=1, cpu_enable=1, ld_ready=0; go to RUN after one cycle.
- RUN: cpu_enable=1, cpu_start=0, ld_ready=0. The only exit is reset.

Rules:
- Byte order is big-endian: first byte → [15:8].
- ptr is ADDR_W+1 bits wide.
- A transfer occurs only when ld_valid && ld_ready. Bubbles are allowed anywhere in an image.
- CPU stores: dmem[d_addr]<=dataout on a rising edge with wena=1, only in RUN. wena in any other state is ignored.
- Read-during-write to the same dmem address: datain shows the old word before the edge and the new word after it.
- Memory arrays are not cleared by reset.

## Timing
- Reset values: ld_ready=0 while reset is high; state=IDLE; cpu_enable=0, cpu_start=0, busy=0, ld_err=0, instruction=0.
- datain reflects dmem contents and is undefined until that address is written.
- Loader write latency: the word is visible on the read port the cycle after its low byte is accepted.
- KICK follows the cycle after the final imem low byte is accepted. cpu_start is high for exactly one cycle.
- Fetch and load reads have zero latency, matching the CPU sampling instruction and datain at the same edge that presents the address.
- Reset mid-image: return to IDLE, discard the partial word, clear ld_err. Words already written remain.

## Configuration
- PCPU_MEM_DUMP_EN defined: adds port dump_addr (in, ADDR_W) and dump_data (out, 16). dump_data is a combinational second read port on dmem for bench and debug readback. It has no effect on any other behaviour.
- PCPU_MEM_DUMP_EN undefined: both ports are absent.

## Structure
- Package pcpu_mem_pkg holds:
  - the state enum (IDLE, HI, LO, DRAIN, KICK, RUN);
  - NOP_WORD = 16'h0000;
  - the SEL_IMEM/SEL_DMEM constants.
- Sub-module pcpu_mem_loader holds the FSM, byte assembler, ptr and the error flag. It emits a write strobe, target, address and word.
- The top level holds both arrays, the CPU ports and the output gating.

## Test plan
- Reset, then dmem image 12,34,56,78 (sel=1, last on 78) → dmem[0]=0x1234, dmem[1]=0x5678; state IDLE; cpu_enable=0; ld_err=0.
- imem image 20,01,10,00 (sel=0) with a ld_valid bubble → imem[0]=0x2001, imem[1]=0x1000; cpu_start high exactly one cycle; cpu_enable stays 1; instruction at i_addr=1 reads 0x1000.
- Odd image 11,22,33 (last on 33) → ld_err=1; imem[1] unchanged; cpu_start never asserted.
- 514-byte dmem image → 256 words written; ld_err=1; last 2 bytes dropped; returns to IDLE after ld_last.
- In RUN, wena=1, d_addr=0x10, dataout=0xBEEF → next cycle datain=0xBEEF. The same store in IDLE leaves dmem[0x10] unchanged.
- Reset asserted after a high byte → IDLE, ld_err=0, ld_ready=1; a following 2-byte image writes word 0.
